alu_issue_ctrl: RTL and testbench

- Front-end issuer for the 27-bit ALU instruction interface: opcode[26:24] | operand1[23:12] | operand2[11:0] in, 12-bit result out.
- Accepts operation requests over a valid/ready handshake and buffers them in a small FIFO.
- Drives one registered instruction word into the combinational ALU, captures its 12-bit result one cycle later, and returns it in order with the request tag.
- Sits between the sequencing logic and the ALU.

---
 rtl/alu_issue_ctrl_pkg.sv | 30 +++
 rtl/alu_req_fifo.sv | 61 ++++++
 rtl/alu_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared opcodes, instruction field layout and FSM encoding for the ALU issuer.
// Pure declarations: no latency and no handshake.
package alu_issue_ctrl_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_UMUL = 3'd3;
    localparam logic [2:0] OP_SMUL = 3'd4;
    localparam logic [2:0] OP_FADD = 3'd5;
    localparam logic [2:0] OP_FMUL = 3'd6;
    localparam logic [2:0] OP_CMP  = 3'd7;

    localparam int OPC_MSB = 26;
    localparam int OPC_LSB = 24;
    localparam int OP1_MSB = 23;
    localparam int OP1_LSB = 12;
    localparam int OP2_MSB = 11;
    localparam int OP2_LSB = 0;

    localparam int INSTR_W = 27;
    localparam int DATA_W  = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO: pop_dat shows the head combinationally, push/pop take effect on the clock edge.
// Backpressure: full comes from the registered count, so a same-cycle pop never admits a push.
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues buffered ALU requests one at a time and returns results in order with their tags.
// Request-to-response latency 3 cycles when idle; rsp_valid holds until rsp_ready, req_ready = !full.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_opcode,
    input  logic [DATA_W-1:0]  req_op1,
    input  logic [DATA_W-1:0]  req_op2,
    input  logic [TAG_W-1:0]   req_tag,
    output logic [INSTR_W-1:0] alu_instruction,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic [15:0]        issue_count,
    output logic               busy
);

    localparam int FIFO_W = INSTR_W + TAG_W;

    logic              fifo_full, fifo_empty, fifo_pop;
    logic [FIFO_W-1:0] fifo_dat;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic [15:0]        issue_count_q, issue_count_d;

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .W     (FIFO_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (req_valid && !fifo_full),
        .push_dat ({req_opcode, req_op1, req_op2, req_tag}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign req_ready       = !fifo_full;
    assign alu_instruction = instr_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_tag         = rsp_tag_q;
    assign issue_count     = issue_count_q;
    assign busy            = !fifo_empty || (state_q != IDLE);

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        tag_d         = tag_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_tag_d     = rsp_tag_q;
        issue_count_d = issue_count_q;
        fifo_pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    instr_d  = fifo_dat[FIFO_W-1:TAG_W];
                    tag_d    = fifo_dat[TAG_W-1:0];
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_result;
                rsp_tag_d   = tag_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    issue_count_d = issue_count_q + 16'd1;
                    // Chain straight into the next request to sustain one response per 2 cycles.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        instr_d  = fifo_dat[FIFO_W-1:TAG_W];
                        tag_d    = fifo_dat[TAG_W-1:0];
                        state_d  = EXEC;
                    end else begin
                        instr_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            instr_q       <= '0;
            tag_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_tag_q     <= '0;
            issue_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            tag_q         <= tag_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_tag_q     <= rsp_tag_d;
            issue_count_q <= issue_count_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed and randomized checks of alu_issue_ctrl against an in-order response queue model
// driven by a simple 8-bit integer ALU stand-in.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [2:0]         req_opcode = 3'd0;
    logic [11:0]        req_op1 = 12'd0;
    logic [11:0]        req_op2 = 12'd0;
    logic [TAG_W-1:0]   req_tag = '0;
    logic [INSTR_W-1:0] alu_instruction;
    logic [11:0]        alu_result;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [11:0]        rsp_data;
    logic [TAG_W-1:0]   rsp_tag;
    logic [15:0]        issue_count;
    logic               busy;

    alu_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_opcode      (req_opcode),
        .req_op1         (req_op1),
        .req_op2         (req_op2),
        .req_tag         (req_tag),
        .alu_instruction (alu_instruction),
        .alu_result      (alu_result),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_tag         (rsp_tag),
        .issue_count     (issue_count),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU stand-in: integer ops work on the low 8 operand bits, float ops are arbitrary mixes.
    function automatic logic [11:0] alu_ref(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b);
        logic signed [7:0]  sa, sb;
        logic signed [15:0] sp;
        logic [15:0]        up;
        logic [7:0]         r8;
        sa = a[7:0];
        sb = b[7:0];
        case (op)
            3'd1:    r8 = a[7:0] + b[7:0];
            3'd2:    r8 = a[7:0] - b[7:0];
            3'd3:    begin up = a[7:0] * b[7:0]; r8 = up[7:0]; end
            3'd4:    begin sp = sa * sb; r8 = sp[7:0]; end
            3'd5:    return a ^ b;
            3'd6:    return a & ~b;
            3'd7:    return (a < b) ? 12'd1 : 12'd0;
            default: return 12'd0;
        endcase
        return {4'h0, r8};
    endfunction

    assign alu_result = alu_ref(alu_instruction[OPC_MSB:OPC_LSB],
                                alu_instruction[OP1_MSB:OP1_LSB],
                                alu_instruction[OP2_MSB:OP2_LSB]);

    typedef struct {
        logic [11:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          failed = 0;
    int          n_rsp = 0;
    int unsigned rsp_cyc[$];
    logic [11:0] rsp_dat_log[$];
    logic [3:0]  rsp_tag_log[$];
    logic [15:0] model_cnt = 16'd0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
        end
    endtask

    // Response monitor: in-order scoreboard plus stability of held responses.
    logic        held = 1'b0;
    logic [11:0] held_dat;
    logic [3:0]  held_tag;
    exp_t        e;
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else if (rsp_valid) begin
            if (held) begin
                chk("hold_data", 32'(rsp_data), 32'(held_dat));
                chk("hold_tag", 32'(rsp_tag), 32'(held_tag));
            end
            if (rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                end
                rsp_cyc.push_back(cyc);
                rsp_dat_log.push_back(rsp_data);
                rsp_tag_log.push_back(rsp_tag);
                n_rsp++;
                model_cnt++;
                held = 1'b0;
            end else begin
                held     = 1'b1;
                held_dat = rsp_data;
                held_tag = rsp_tag;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic step();
        if (req_valid && req_ready && !rst)
            exp_q.push_back('{alu_ref(req_opcode, req_op1, req_op2), req_tag});
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b, input logic [3:0] t);
        req_valid  = 1'b1;
        req_opcode = op;
        req_op1    = a;
        req_op2    = b;
        req_tag    = t;
    endtask

    task automatic rand_req();
        set_req(3'($urandom), 12'($urandom), 12'($urandom), 4'($urandom));
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 200) begin
            step();
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'(0));
    endtask

    int base;
    int acc_n;
    logic acc;

    initial begin
        // Reset state
        step();
        step();
        chk("rst_instr", 32'(alu_instruction), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_req_ready", 32'(req_ready), 32'(1));
        chk("rst_issue_count", 32'(issue_count), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rsp_data", 32'(rsp_data), 32'(0));
        chk("rst_rsp_tag", 32'(rsp_tag), 32'(0));
        rst = 1'b0;
        step();

        // Single add: instruction at T+2, response at T+3
        rsp_ready = 1'b1;
        set_req(OP_ADD, 12'h012, 12'h034, 4'd5);
        step();
        req_valid = 1'b0;
        step();
        chk("add_instr", 32'(alu_instruction), 32'h1012034);
        chk("add_early_valid", 32'(rsp_valid), 32'(0));
        step();
        chk("add_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("add_rsp_data", 32'(rsp_data), 32'h046);
        chk("add_rsp_tag", 32'(rsp_tag), 32'(5));
        step();
        chk("add_count", 32'(issue_count), 32'(1));
        chk("add_idle_busy", 32'(busy), 32'(0));
        chk("add_instr_cleared", 32'(alu_instruction), 32'(0));

        // Back-to-back burst
        base = n_rsp;
        set_req(OP_SUB, 12'h005, 12'h003, 4'd1);
        step();
        set_req(OP_UMUL, 12'h00F, 12'h00F, 4'd2);
        step();
        set_req(OP_ADD, 12'h0FF, 12'h001, 4'd3);
        step();
        req_valid = 1'b0;
        wait_drain("burst_drain");
        step();
        chk("burst_n", 32'(n_rsp - base), 32'(3));
        if (n_rsp - base == 3) begin
            chk("burst_d0", 32'(rsp_dat_log[base]), 32'h002);
            chk("burst_t0", 32'(rsp_tag_log[base]), 32'(1));
            chk("burst_d1", 32'(rsp_dat_log[base+1]), 32'h0E1);
            chk("burst_t1", 32'(rsp_tag_log[base+1]), 32'(2));
            chk("burst_d2", 32'(rsp_dat_log[base+2]), 32'h000);
            chk("burst_t2", 32'(rsp_tag_log[base+2]), 32'(3));
            chk("burst_gap1", rsp_cyc[base+1] - rsp_cyc[base], 32'(2));
            chk("burst_gap2", rsp_cyc[base+2] - rsp_cyc[base+1], 32'(2));
        end
        chk("burst_count", 32'(issue_count), 32'(4));

        // Full / backpressure
        rsp_ready = 1'b0;
        base  = n_rsp;
        acc_n = 0;
        rand_req();
        for (int c = 0; c < 14; c++) begin
            acc = req_valid && req_ready;
            step();
            if (acc) begin
                acc_n++;
                if (acc_n < DEPTH + 2) rand_req();
                else req_valid = 1'b0;
            end
        end
        chk("bp_accepts", 32'(acc_n), 32'(DEPTH + 1));
        chk("bp_req_ready", 32'(req_ready), 32'(0));
        chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("bp_busy", 32'(busy), 32'(1));
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain("bp_drain");
        chk("bp_drained_n", 32'(n_rsp - base), 32'(DEPTH + 1));

        // Nop forwarded and answered with its tag
        set_req(OP_NOP, 12'hABC, 12'h123, 4'd9);
        step();
        req_valid = 1'b0;
        wait_drain("nop_drain");
        chk("nop_data", 32'(rsp_dat_log[n_rsp-1]), 32'h000);
        chk("nop_tag", 32'(rsp_tag_log[n_rsp-1]), 32'(9));
        step();

        // Reset during EXEC discards everything
        set_req(OP_ADD, 12'h001, 12'h002, 4'd7);
        step();
        set_req(OP_SUB, 12'h009, 12'h004, 4'd8);
        step();
        req_valid = 1'b0;
        chk("mid_instr", 32'(alu_instruction), 32'h1001002);
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        model_cnt = 16'd0;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("mid_instr_zero", 32'(alu_instruction), 32'(0));
        chk("mid_busy", 32'(busy), 32'(0));
        chk("mid_req_ready", 32'(req_ready), 32'(1));
        chk("mid_count", 32'(issue_count), 32'(0));
        base = n_rsp;
        for (int c = 0; c < 10; c++) step();
        chk("mid_no_stale", 32'(n_rsp - base), 32'(0));

        // Randomized traffic with random consumer stalls
        for (int c = 0; c < 400; c++) begin
            if (!req_valid && $urandom_range(0, 2) != 0) rand_req();
            rsp_ready = ($urandom_range(0, 3) != 0);
            acc = req_valid && req_ready;
            step();
            if (acc) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain("rand_drain");
        step();
        chk("rand_count", 32'(issue_count), 32'(model_cnt));

        // Counter wrap
        force dut.issue_count_q = 16'hFFFF;
        #1;
        release dut.issue_count_q;
        model_cnt = 16'hFFFF;
        chk("wrap_pre", 32'(issue_count), 32'hFFFF);
        set_req(OP_CMP, 12'h001, 12'h002, 4'd4);
        step();
        req_valid = 1'b0;
        wait_drain("wrap_drain");
        step();
        chk("wrap_post", 32'(issue_count), 32'h0000);
        chk("wrap_model", 32'(issue_count), 32'(model_cnt));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
